// File: rtl/uart_nco_pkg.sv
// uart_nco_pkg: shared constants, channel state and increment helper
// for the fractional NCO clock generator.
package uart_nco_pkg;

  localparam int ACC_W_DEF = 32;
  localparam longint unsigned REF_HZ = 64'd50_000_000;
  localparam logic [31:0] DEFAULT_INC = 32'd158329503;

  typedef enum logic [1:0] {
    IDLE_RUN,
    PENDING,
    APPLY
  } ch_state_e;

  // round(hz * 2^32 / REF_HZ)
  function automatic logic [31:0] calc_inc(input longint unsigned hz);
    longint unsigned num;
    num = (hz << 32) + (REF_HZ >> 1);
    return 32'(num / REF_HZ);
  endfunction

endpackage

// File: rtl/uart_nco_clkgen_if.sv
// uart_nco_clkgen_if: increment-update handshake between a
// configuration master and the NCO clock generator.
interface uart_nco_clkgen_if
  import uart_nco_pkg::*;
#(
  parameter int CH_W  = 1,
  parameter int ACC_W = ACC_W_DEF
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc,
    output cfg_ready, cfg_err
  );

endinterface

// File: rtl/uart_nco_channel.sv
// uart_nco_channel: one NCO phase accumulator with tick, square
// wave, lock tracking and glitch-free increment updates.
module uart_nco_channel
  import uart_nco_pkg::*;
#(
  parameter int               ACC_W      = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_RST    = ACC_W'(uart_nco_pkg::DEFAULT_INC),
  parameter int               LOCK_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             tick,
  output logic             clk_out,
  output logic             locked,
  output logic             pending
);

  localparam int LW = $clog2(LOCK_TICKS + 1);

  ch_state_e        state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] nxt_inc;
  logic [LW-1:0]    lock_cnt;
  logic [ACC_W:0]   sum;
  logic             run;
  logic             carry;
  logic             quick;
  logic             apply;
  logic             lock_nxt;

  always_comb begin
    run   = en && (inc != '0);
    sum   = {1'b0, acc} + {1'b0, inc};
    carry = run && sum[ACC_W];
    // a stopped or halting channel has no carry to wait for
    quick = !en || (inc == '0) || (nxt_inc == '0);
    apply = (state == PENDING) && (quick || carry);
    lock_nxt = run && !apply &&
      ((lock_cnt == LW'(LOCK_TICKS)) ||
       (carry && lock_cnt == LW'(LOCK_TICKS - 1)));
  end

  assign pending = (state == PENDING);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE_RUN;
      acc      <= '0;
      inc      <= INC_RST;
      nxt_inc  <= '0;
      lock_cnt <= '0;
      tick     <= 1'b0;
      clk_out  <= 1'b0;
      locked   <= 1'b0;
    end else begin
      tick   <= carry;
      locked <= lock_nxt;
      if (run) begin
        acc     <= sum[ACC_W-1:0];
        clk_out <= sum[ACC_W-1];
      end
      unique case (state)
        IDLE_RUN: begin
          if (wr) begin
            state   <= PENDING;
            nxt_inc <= wr_inc;
          end
        end
        PENDING: begin
          if (apply) begin
            state <= APPLY;
            inc   <= nxt_inc;
          end
        end
        APPLY:   state <= IDLE_RUN;
        default: state <= IDLE_RUN;
      endcase
      if (apply || !run) begin
        lock_cnt <= '0;
      end else if (carry && lock_cnt != LW'(LOCK_TICKS)) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_nco_clkgen.sv
// uart_nco_clkgen: multi-channel runtime-programmable fractional
// clock generator; owns the config handshake and channel decode.
module uart_nco_clkgen
  import uart_nco_pkg::*;
#(
  parameter int               NUM_CH      = 2,
  parameter int               ACC_W       = ACC_W_DEF,
  parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(uart_nco_pkg::DEFAULT_INC),
  parameter int               LOCK_TICKS  = 4,
  localparam int              CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  uart_nco_clkgen_if.slave  cfg,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] locked
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] pend;
  logic              xfer;
  logic              ch_ok;

  assign xfer  = cfg.cfg_valid && cfg.cfg_ready;
  assign ch_ok = |hit;

  // one update outstanding block-wide: ready waits for the apply
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cfg.cfg_ready <= 1'b0;
      cfg.cfg_err   <= 1'b0;
    end else begin
      cfg.cfg_err   <= xfer && !ch_ok;
      cfg.cfg_ready <= !(xfer && ch_ok) && !(|pend);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign hit[c] = (cfg.cfg_ch == CH_W'(c));

    uart_nco_channel #(
      .ACC_W      (ACC_W),
      .INC_RST    (DEFAULT_INC),
      .LOCK_TICKS (LOCK_TICKS)
    ) u_ch (
      .clk     (refclk),
      .rst     (rst),
      .en      (en[c]),
      .wr      (xfer && hit[c]),
      .wr_inc  (cfg.cfg_inc),
      .tick    (tick[c]),
      .clk_out (clk_out[c]),
      .locked  (locked[c]),
      .pending (pend[c])
    );
  end

endmodule

// File: tb/tb_uart_nco_clkgen.sv
// tb_uart_nco_clkgen: directed and randomized checks of the NCO
// clock generator against a behavioural phase model.
module tb_uart_nco_clkgen;
  import uart_nco_pkg::*;

  localparam int NCH = 3;
  localparam int L   = 4;
  localparam longint unsigned MOD = 64'h1_0000_0000;
  localparam longint unsigned DEF = 64'd158329503;

  logic           refclk = 1'b0;
  logic           rst    = 1'b1;
  logic [NCH-1:0] en     = '0;
  logic [NCH-1:0] tick, clk_out, locked;

  uart_nco_clkgen_if #(.CH_W(2), .ACC_W(32)) cfg ();

  uart_nco_clkgen #(
    .NUM_CH     (NCH),
    .LOCK_TICKS (L)
  ) dut (
    .refclk  (refclk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg),
    .tick    (tick),
    .clk_out (clk_out),
    .locked  (locked)
  );

  always #5 refclk = ~refclk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // behavioural model: phase as a plain integer, carry = wrap past 2^32
  longint unsigned m_acc [NCH];
  longint unsigned m_inc [NCH];
  longint unsigned m_pinc[NCH];
  bit              m_pend[NCH];
  int              m_lock[NCH];
  bit              m_tick[NCH];
  bit              m_clk [NCH];
  bit              m_ready;
  bit              m_err;

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0; m_inc[c] = DEF; m_pinc[c] = 0;
      m_pend[c] = 0; m_lock[c] = 0;
      m_tick[c] = 0; m_clk[c] = 0;
    end
    m_ready = 0;
    m_err   = 0;
  endtask

  task automatic m_step();
    bit xfer, ok, busy, run, carry, apply;
    int ch;
    longint unsigned s;
    xfer = cfg.cfg_valid && m_ready;
    ch   = int'(cfg.cfg_ch);
    ok   = ch < NCH;
    busy = 0;
    for (int c = 0; c < NCH; c++) busy |= m_pend[c];
    for (int c = 0; c < NCH; c++) begin
      run   = en[c] && m_inc[c] != 0;
      s     = m_acc[c] + m_inc[c];
      carry = run && s >= MOD;
      apply = m_pend[c] &&
              (!en[c] || m_inc[c] == 0 || m_pinc[c] == 0 || carry);
      if (run) begin
        m_acc[c] = s % MOD;
        m_clk[c] = ((m_acc[c] >> 31) & 1) != 0;
      end
      m_tick[c] = carry;
      if (apply || !run) m_lock[c] = 0;
      else if (carry && m_lock[c] < L) m_lock[c]++;
      if (apply) begin
        m_inc[c]  = m_pinc[c];
        m_pend[c] = 0;
      end
      if (xfer && ok && ch == c) begin
        m_pend[c] = 1;
        m_pinc[c] = cfg.cfg_inc;
      end
    end
    m_ready = !(xfer && ok) && !busy;
    m_err   = xfer && !ok;
  endtask

  always @(posedge refclk) begin
    if (rst) m_reset();
    else m_step();
  end

  // per-cycle compare of every output against the model
  always @(negedge refclk) begin
    logic [NCH-1:0] et, ec, el;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c];
      ec[c] = m_clk[c];
      el[c] = (m_lock[c] == L);
    end
    cyc++;
    tests++;
    if ({tick, clk_out, locked, cfg.cfg_ready, cfg.cfg_err} !==
        {et, ec, el, m_ready, m_err}) begin
      fails++;
      $display("FAIL model cyc=%0d tick/clk/lock/rdy/err got %b %b %b %b %b want %b %b %b %b %b",
               cyc, tick, clk_out, locked, cfg.cfg_ready, cfg.cfg_err,
               et, ec, el, m_ready, m_err);
    end
  end

  task automatic check(input string name, input longint got,
                       input longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // call at a negedge; returns at the negedge after the transfer edge
  task automatic cfg_write(input int ch, input logic [31:0] v);
    int n;
    bit took;
    n = 0;
    took = 0;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_ch    = 2'(ch);
    cfg.cfg_inc   = v;
    do begin
      took = cfg.cfg_ready;
      @(negedge refclk);
      n++;
    end while (!took && n < 5000);
    cfg.cfg_valid = 1'b0;
    check("cfg_write_accepted", took, 1);
  endtask

  // directed and random stimulus
  initial begin
    int cnt0, cnt1, first, lock_at, last, smin, smax, tog, n, r, k;
    bit prev;
    logic [31:0] v;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_ch    = '0;
    cfg.cfg_inc   = '0;

    @(negedge refclk);
    check("reset_ready", cfg.cfg_ready, 0);
    check("reset_tick", tick, 0);
    en = '1;
    #2 rst = 1'b0;

    cnt0 = 0; first = 0; lock_at = 0; last = 0; smin = 1000; smax = 0;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge refclk);
      if (i == 1) check("ready_after_release", cfg.cfg_ready, 1);
      if (tick[0]) begin
        cnt0++;
        if (first == 0) first = i;
        if (last != 0) begin
          if (i - last < smin) smin = i - last;
          if (i - last > smax) smax = i - last;
        end
        last = i;
      end
      if (locked[0] && lock_at == 0) lock_at = cnt0;
    end
    check("first_tick_cycle", first, 28);
    check("lock_after_ticks", lock_at, 4);
    check("spacing_min", smin, 27);
    check("spacing_max", smax, 28);
    check("tick_count_3000", cnt0, longint'((3000 * DEF) >> 32));

    cfg_write(1, 32'h8000_0000);
    check("ready_drops", cfg.cfg_ready, 0);
    n = 0;
    while (!cfg.cfg_ready && n < 200) begin
      @(negedge refclk);
      n++;
    end
    check("ready_returns", cfg.cfg_ready, 1);
    cnt1 = 0; tog = 0; prev = clk_out[1];
    repeat (40) begin
      @(negedge refclk);
      cnt1 += int'(tick[1]);
      tog  += int'(clk_out[1] != prev);
      prev  = clk_out[1];
    end
    check("ch1_ticks_40", cnt1, 20);
    check("ch1_toggles_40", tog, 40);

    cfg_write(3, 32'h1234_5678);
    check("err_pulse", cfg.cfg_err, 1);
    check("err_ready", cfg.cfg_ready, 1);
    @(negedge refclk);
    check("err_clears", cfg.cfg_err, 0);

    cfg_write(0, 32'h0);
    step(2);
    cnt0 = 0;
    repeat (60) begin
      @(negedge refclk);
      cnt0 += int'(tick[0]);
    end
    check("halt_no_ticks", cnt0, 0);
    check("halt_unlocked", locked[0], 0);
    cfg_write(0, 32'(DEF));
    step(200);
    check("relock_default", locked[0], 1);

    en[0] = 1'b0;
    cnt0 = 0;
    repeat (100) begin
      @(negedge refclk);
      cnt0 += int'(tick[0]);
    end
    check("disabled_no_ticks", cnt0, 0);
    check("disabled_unlocked", locked[0], 0);
    en[0] = 1'b1;
    step(50);

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) begin
        en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : '1;
        step($urandom_range(1, 40));
      end else begin
        k = $urandom_range(0, 3);
        case (k)
          0:       v = 32'(DEF);
          1:       v = 32'h8000_0000;
          2:       v = 32'h0;
          default: v = 32'h0100_0000 | 32'($urandom);
        endcase
        cfg_write($urandom_range(0, 3), v);
        step($urandom_range(0, 10));
      end
    end

    en = '1;
    cfg_write(0, 32'(DEF));
    step(60);
    cfg_write(0, 32'h0200_0000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs",
          {tick, clk_out, locked, cfg.cfg_ready, cfg.cfg_err}, 0);
    @(negedge refclk);
    @(negedge refclk);
    #2 rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge refclk);
      if (tick[0] && first == 0) first = i;
    end
    check("post_rst_first_tick", first, 28);
    step(300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
